i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_sync_edge.sv | 41 ++++
 rtl/i2c_target.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared state encoding and bus constants for the I2C target.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam int   BYTE_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Multi-flop synchronizer with rise/fall detect on one bus line.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_arm;

    // Edges are masked until the chain has refilled after reset, so a line
    // already low at reset release cannot look like a 1->0 transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '1;
            r_prev  <= 1'b1;
            r_arm   <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
            r_prev  <= r_chain[SYNC_STAGES-1];
            r_arm   <= {r_arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync = r_chain[SYNC_STAGES-1];
    assign rise = r_arm[SYNC_STAGES] &  sync & ~r_prev;
    assign fall = r_arm[SYNC_STAGES] & ~sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target
//  Description : 7-bit address I2C target with byte write/read handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h52,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam logic [2:0] c_last_bit = 3'(BYTE_BITS - 1);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scl_i),
        .sync  (w_scl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sda_i),
        .sync  (w_sda),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_t, w_sda_t_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack_ok, w_ack_ok_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_start_det, r_stop_det;
    logic [7:0] w_rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_sda_t     <= 1'b1;
            r_rw        <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_t     <= w_sda_t_nxt;
            r_rw        <= w_rw_nxt;
            r_ack_ok    <= w_ack_ok_nxt;
            r_busy      <= w_busy_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_req    <= w_tx_req_nxt;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
        end
    end

    assign w_rx_byte = {r_shift[6:0], w_sda};

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_sda_t_nxt    = r_sda_t;
        w_rw_nxt       = r_rw;
        w_ack_ok_nxt   = r_ack_ok;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;

        if (w_stop) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = 3'd0;
            w_sda_t_nxt   = 1'b1;
            w_ack_ok_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ADDR;
            w_bit_cnt_nxt = 3'd0;
            w_sda_t_nxt   = 1'b1;
            w_ack_ok_nxt  = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            if (w_rx_byte[7:1] == TARGET_ADDR) begin
                                w_state_nxt = ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_rx_byte[0];
                                if (w_rx_byte[0]) begin
                                    w_shift_nxt  = tx_data;
                                    w_tx_req_nxt = 1'b1;
                                end
                            end else begin
                                w_state_nxt = IGNORE;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end
                // First SCL fall pulls ACK onto the bus, the second ends the
                // 9th clock; on a read that same edge presents the MSB.
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_sda_t) begin
                            w_sda_t_nxt = ACK;
                        end else if (r_rw) begin
                            w_state_nxt = RD_DATA;
                            w_sda_t_nxt = r_shift[7];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end else begin
                            w_state_nxt = WR_DATA;
                            w_sda_t_nxt = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            w_rx_data_nxt  = w_rx_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_sda_t) begin
                            w_sda_t_nxt = ACK;
                        end else begin
                            w_sda_t_nxt = 1'b1;
                            w_state_nxt = WR_DATA;
                        end
                    end
                end
                // Open-drain: releasing the line puts a 1 on the bus, so the
                // tristate control follows the data bit directly.
                RD_DATA: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_last_bit) begin
                            w_sda_t_nxt = 1'b1;
                            w_state_nxt = RD_ACK;
                        end else begin
                            w_sda_t_nxt = r_shift[7];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    w_sda_t_nxt = 1'b1;
                    if (w_scl_rise) begin
                        if (w_sda == NACK) begin
                            w_state_nxt = IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_shift_nxt  = tx_data;
                            w_tx_req_nxt = 1'b1;
                            w_ack_ok_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_ack_ok) begin
                        w_ack_ok_nxt = 1'b0;
                        w_state_nxt  = RD_DATA;
                        w_sda_t_nxt  = r_shift[7];
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                    end
                end
                default: begin
                    w_sda_t_nxt = 1'b1;
                end
            endcase
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = r_sda_t;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Bus-level controller model and scoreboard for i2c_target.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

    localparam int c_t = 100;  // quarter SCL period; clk period is 10

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_o, sda_t, rx_valid, tx_req, start_det, stop_det, busy;
    logic [7:0] rx_data;
    wire        sda_bus = m_sda & (sda_t ? 1'b1 : sda_o);

    int n_cmp = 0;
    int n_err = 0;
    int n_rx = 0, n_tx = 0, n_start = 0, n_stop = 0;
    logic low_seen = 1'b0;
    logic [7:0] q_rx[$];
    logic [7:0] q_rd[$];

    always #5 clk = ~clk;

    i2c_target u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (m_scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx++;
            if (q_rx.size() == 0) check("rx_spurious", 32'd1, 32'd0);
            else                  check("rx_data", {24'd0, rx_data}, {24'd0, q_rx.pop_front()});
        end
        if (tx_req)    n_tx++;
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (!sda_t)    low_seen = 1'b1;
    end

    task automatic bit_out(input logic b);
        m_sda = b;  #(c_t);
        m_scl = 1'b1; #(2*c_t);
        m_scl = 1'b0; #(c_t);
    endtask

    task automatic bit_in(output logic b);
        m_sda = 1'b1; #(c_t);
        m_scl = 1'b1; #(c_t);
        b = sda_bus;  #(c_t);
        m_scl = 1'b0; #(c_t);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #(c_t);
        m_scl = 1'b1; #(c_t);
        m_sda = 1'b0; #(c_t);
        m_scl = 1'b0; #(c_t);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(c_t);
        m_scl = 1'b1; #(c_t);
        m_sda = 1'b1; #(c_t);
    endtask

    task automatic set_tx(input logic [7:0] b);
        tx_data = b;
        q_rd.push_back(b);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(ack);
    endtask

    task automatic read_byte(input string tag, input logic ack_bit,
                             input logic load_next, input logic [7:0] next_tx);
        logic [7:0] b;
        logic       x;
        for (int i = 7; i >= 0; i--) begin
            bit_in(x);
            b[i] = x;
        end
        if (load_next) set_tx(next_tx);
        if (q_rd.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
        else                  check(tag, {24'd0, b}, {24'd0, q_rd.pop_front()});
        bit_out(ack_bit);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        int   s_rx, s_tx, s_start, s_stop;
        logic x;

        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_t",    {31'd0, sda_t},     32'd1);
        check("rst_sda_o",    {31'd0, sda_o},     32'd0);
        check("rst_rx_data",  {24'd0, rx_data},   32'd0);
        check("rst_pulses",   {28'd0, rx_valid, tx_req, start_det, stop_det}, 32'd0);
        check("rst_busy",     {31'd0, busy},      32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("rst_no_start", n_start, 0);
        check("rst_no_stop",  n_stop,  0);

        // Single write of 0xA5 to our address
        s_rx = n_rx; s_start = n_start; s_stop = n_stop;
        i2c_start();
        write_byte(8'hA4, ack);  check("w_addr_ack", {31'd0, ack}, 32'd0);
        q_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);  check("w_data_ack", {31'd0, ack}, 32'd0);
        check("w_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        #(c_t);
        check("w_rx_data",  {24'd0, rx_data}, 32'hA5);
        check("w_rx_count", n_rx - s_rx, 1);
        check("w_start",    n_start - s_start, 1);
        check("w_stop",     n_stop - s_stop, 1);
        check("w_busy_end", {31'd0, busy}, 32'd0);

        // Single read of 0x3C terminated by NACK
        s_tx = n_tx;
        set_tx(8'h3C);
        i2c_start();
        write_byte(8'hA5, ack);  check("r_addr_ack", {31'd0, ack}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd1);
        read_byte("r_byte", 1'b1, 1'b0, 8'h00);
        check("r_tx_req",   n_tx - s_tx, 1);
        check("r_busy_end", {31'd0, busy}, 32'd0);
        i2c_stop();

        // Foreign address must never be acknowledged or delivered
        s_rx = n_rx;
        #(c_t);
        low_seen = 1'b0;
        i2c_start();
        write_byte(8'h22, ack);  check("x_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'hFF, ack);  check("x_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        #(c_t);
        check("x_sda_low",  {31'd0, low_seen}, 32'd0);
        check("x_rx_count", n_rx - s_rx, 0);

        // Write then repeated START into a two-byte read
        s_tx = n_tx; s_start = n_start; s_stop = n_stop;
        i2c_start();
        write_byte(8'hA4, ack);  check("rs_waddr_ack", {31'd0, ack}, 32'd0);
        q_rx.push_back(8'h01);
        write_byte(8'h01, ack);  check("rs_wdata_ack", {31'd0, ack}, 32'd0);
        set_tx(8'hDE);
        i2c_start();
        write_byte(8'hA5, ack);  check("rs_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte("rs_byte0", 1'b0, 1'b1, 8'hAD);
        read_byte("rs_byte1", 1'b1, 1'b0, 8'h00);
        i2c_stop();
        #(c_t);
        check("rs_tx_req", n_tx - s_tx, 2);
        check("rs_start",  n_start - s_start, 2);
        check("rs_stop",   n_stop - s_stop, 1);

        // Reset in the middle of a read byte, then a fresh write
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA5, ack);  check("mr_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) bit_in(x);
        check("mr_driving", {31'd0, sda_t}, 32'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mr_sda_t", {31'd0, sda_t}, 32'd1);
        check("mr_busy",  {31'd0, busy},  32'd0);
        rst_n = 1'b1;
        s_start = n_start; s_stop = n_stop; s_rx = n_rx;
        repeat (20) @(posedge clk);
        check("mr_no_start", n_start - s_start, 0);
        check("mr_no_stop",  n_stop - s_stop, 0);
        i2c_start();
        write_byte(8'hA4, ack);  check("mr_waddr_ack", {31'd0, ack}, 32'd0);
        q_rx.push_back(8'h5A);
        write_byte(8'h5A, ack);  check("mr_wdata_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        #(c_t);
        check("mr_rx_data",  {24'd0, rx_data}, 32'h5A);
        check("mr_rx_count", n_rx - s_rx, 1);

        check("q_rx_empty", q_rx.size(), 0);
        check("q_rd_empty", q_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
